// File: rtl/cprv_writeback.sv
// Writeback stage: registers ALU results into the register-file write port and
// sequences a single outstanding load through extraction, extension and alignment checks.
module cprv_writeback #(
  parameter int DATA_WIDTH    = 64,
  parameter int REGADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic [REGADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                     ex_rd_we,
  input  logic                     ex_is_load,
  input  logic [2:0]               ex_funct3,
  input  logic [2:0]               ex_addr_lo,
  input  logic [DATA_WIDTH-1:0]    ex_result,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [REGADDR_WIDTH-1:0] rd_addr,
  output logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     wb_busy,
  output logic                     err_misalign,
  output logic                     err_spurious
);

  typedef enum logic {IDLE, LOAD_WAIT} state_e;

  typedef struct packed {
    logic [REGADDR_WIDTH-1:0] rd;
    logic                     we;
    logic [2:0]               f3;
    logic [2:0]               lo;
  } ld_ctx_t;

  state_e                   state_q, state_d;
  ld_ctx_t                  ld_q, ld_d;
  logic                     rd_en_q, rd_en_d;
  logic [REGADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                     err_mis_q, err_mis_d;
  logic                     err_spu_q, err_spu_d;

  logic                     accept;
  logic [DATA_WIDTH-1:0]    lane;
  logic [DATA_WIDTH-1:0]    ld_ext;
  logic                     ld_mis;

  assign ex_ready = (state_q == IDLE);
  assign accept   = ex_valid & ex_ready;

  // Pending-load lane extraction and extension; funct3 111 falls into the LD arm.
  always_comb begin
    lane = mem_rdata >> {ld_q.lo, 3'b000};
    case (ld_q.f3)
      3'b000:  ld_ext = {{(DATA_WIDTH-8){lane[7]}},   lane[7:0]};
      3'b001:  ld_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b010:  ld_ext = {{(DATA_WIDTH-32){lane[31]}}, lane[31:0]};
      3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}},      lane[7:0]};
      3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}},     lane[15:0]};
      3'b110:  ld_ext = {{(DATA_WIDTH-32){1'b0}},     lane[31:0]};
      default: ld_ext = lane;
    endcase
    case (ld_q.f3[1:0])
      2'b01:   ld_mis = ld_q.lo[0];
      2'b10:   ld_mis = (ld_q.lo[1:0] != 2'b00);
      2'b11:   ld_mis = (ld_q.lo != 3'b000);
      default: ld_mis = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ld_d      = ld_q;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    rd_data_d = '0;
    err_mis_d = err_mis_q;
    err_spu_d = err_spu_q;
    case (state_q)
      IDLE: begin
        if (mem_rvalid) err_spu_d = 1'b1;
        if (accept) begin
          if (ex_is_load) begin
            ld_d    = '{rd: ex_rd_addr, we: ex_rd_we, f3: ex_funct3, lo: ex_addr_lo};
            state_d = LOAD_WAIT;
          end else if (ex_rd_we && ex_rd_addr != '0) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ex_rd_addr;
            rd_data_d = ex_result;
          end
        end
      end
      LOAD_WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (ld_mis) begin
            err_mis_d = 1'b1;
          end else if (ld_q.we && ld_q.rd != '0) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ld_q.rd;
            rd_data_d = ld_ext;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ld_q      <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      err_mis_q <= 1'b0;
      err_spu_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_q      <= ld_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      err_mis_q <= err_mis_d;
      err_spu_q <= err_spu_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign rd_data      = rd_data_q;
  assign wb_busy      = (state_q == LOAD_WAIT);
  assign err_misalign = err_mis_q;
  assign err_spurious = err_spu_q;

endmodule

// File: tb/tb_cprv_writeback.sv
// Directed bench for cprv_writeback: ALU writes, load extension, misalignment,
// spurious returns and mid-load reset, with hand-computed expectations.
module tb_cprv_writeback;
  logic        clk, rst_n;
  logic        ex_valid, ex_ready, ex_rd_we, ex_is_load;
  logic [4:0]  ex_rd_addr, rd_addr;
  logic [2:0]  ex_funct3, ex_addr_lo;
  logic [63:0] ex_result, mem_rdata, rd_data;
  logic        mem_rvalid, rd_en, wb_busy, err_misalign, err_spurious;

  int checks = 0;
  int errors = 0;

  cprv_writeback #(.DATA_WIDTH(64), .REGADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd_addr(ex_rd_addr),
    .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3),
    .ex_addr_lo(ex_addr_lo), .ex_result(ex_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .wb_busy(wb_busy), .err_misalign(err_misalign), .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_rd_we = 0; ex_is_load = 0; ex_rd_addr = 0;
    ex_funct3 = 0; ex_addr_lo = 0; ex_result = 0;
    mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic offer(input logic ld, input logic [4:0] rd, input logic we,
                       input logic [2:0] f3, input logic [2:0] lo, input logic [63:0] res);
    ex_valid = 1; ex_is_load = ld; ex_rd_addr = rd; ex_rd_we = we;
    ex_funct3 = f3; ex_addr_lo = lo; ex_result = res;
  endtask

  // Issue a load, return data in the first LOAD_WAIT cycle, check the write.
  task automatic load1(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [2:0] lo, input logic [63:0] word,
                       input logic exp_en, input logic [63:0] exp_data);
    offer(1, rd, 1, f3, lo, 64'h0);
    step();
    chk({tag, "_busy"}, {63'h0, wb_busy}, 64'h1);
    chk({tag, "_rdy0"}, {63'h0, ex_ready}, 64'h0);
    idle_inputs();
    mem_rvalid = 1; mem_rdata = word;
    step();
    mem_rvalid = 0;
    chk({tag, "_en"},   {63'h0, rd_en}, {63'h0, exp_en});
    chk({tag, "_addr"}, {59'h0, rd_addr}, exp_en ? {59'h0, rd} : 64'h0);
    chk({tag, "_data"}, rd_data, exp_data);
    chk({tag, "_rdy1"}, {63'h0, ex_ready}, 64'h1);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #3;
    chk("rst_en",   {63'h0, rd_en}, 64'h0);
    chk("rst_busy", {63'h0, wb_busy}, 64'h0);
    chk("rst_errs", {62'h0, err_misalign, err_spurious}, 64'h0);
    step();
    rst_n = 1;
    step();
    chk("rst_rdy", {63'h0, ex_ready}, 64'h1);

    // ALU write then bubble
    offer(0, 5, 1, 0, 0, 64'h1234);
    step();
    idle_inputs();
    chk("alu_en",   {63'h0, rd_en}, 64'h1);
    chk("alu_addr", {59'h0, rd_addr}, 64'd5);
    chk("alu_data", rd_data, 64'h1234);
    step();
    chk("alu_en0",   {63'h0, rd_en}, 64'h0);
    chk("alu_addr0", {59'h0, rd_addr}, 64'h0);
    chk("alu_data0", rd_data, 64'h0);

    // x0 write and we=0 write are suppressed
    offer(0, 0, 1, 0, 0, 64'hFF);
    step();
    idle_inputs();
    chk("x0_en",   {63'h0, rd_en}, 64'h0);
    chk("x0_data", rd_data, 64'h0);
    offer(0, 6, 0, 0, 0, 64'hAA);
    step();
    idle_inputs();
    chk("nowe_en", {63'h0, rd_en}, 64'h0);

    load1("lb",  7, 3'b000, 3, 64'h00000000_80000000, 1, 64'hFFFFFFFF_FFFFFF80);
    // back-to-back: LWU accepted the cycle right after the LB return
    load1("lwu", 9, 3'b110, 4, 64'h89ABCDEF_00000000, 1, 64'h00000000_89ABCDEF);
    load1("lh",  10, 3'b001, 2, 64'h00000000_8001_0000, 1, 64'hFFFFFFFF_FFFF8001);
    load1("lbu", 11, 3'b100, 7, 64'hC3000000_00000000, 1, 64'h00000000_000000C3);
    load1("f7ld", 12, 3'b111, 0, 64'h01234567_89ABCDEF, 1, 64'h01234567_89ABCDEF);
    chk("nomis_yet", {63'h0, err_misalign}, 64'h0);

    // slow memory: data two cycles late, ex_ready held low meanwhile
    offer(1, 13, 1, 3'b010, 4, 64'h0);
    step();
    idle_inputs();
    step();
    chk("slow_rdy", {63'h0, ex_ready}, 64'h0);
    chk("slow_en0", {63'h0, rd_en}, 64'h0);
    mem_rvalid = 1; mem_rdata = 64'h7FFFFFFF_00000000;
    step();
    mem_rvalid = 0;
    chk("slow_data", rd_data, 64'h00000000_7FFFFFFF);

    load1("mis", 3, 3'b010, 2, 64'hFFFFFFFF_FFFFFFFF, 0, 64'h0);
    chk("mis_flag", {63'h0, err_misalign}, 64'h1);
    chk("mis_idle", {63'h0, wb_busy}, 64'h0);

    // spurious return in IDLE
    mem_rvalid = 1; mem_rdata = 64'h55;
    step();
    mem_rvalid = 0;
    chk("spu_flag", {63'h0, err_spurious}, 64'h1);
    chk("spu_en",   {63'h0, rd_en}, 64'h0);
    step();
    chk("sticky", {62'h0, err_misalign, err_spurious}, 64'h3);

    // reset mid LOAD_WAIT drops the load
    offer(1, 14, 1, 3'b011, 0, 64'h0);
    step();
    idle_inputs();
    chk("pre_rst_busy", {63'h0, wb_busy}, 64'h1);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", {63'h0, wb_busy}, 64'h0);
    chk("arst_errs", {62'h0, err_misalign, err_spurious}, 64'h0);
    chk("arst_rdy",  {63'h0, ex_ready}, 64'h1);
    step();
    rst_n = 1;
    step();
    mem_rvalid = 1; mem_rdata = 64'h1111;
    step();
    mem_rvalid = 0;
    chk("post_rst_en",  {63'h0, rd_en}, 64'h0);
    chk("post_rst_spu", {63'h0, err_spurious}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
